// File: rtl/relu_layer2_sequencer.sv
// Drains the ReLU node queue into the layer-2 MAC over valid/ready.
// Define RELU_ZERO_SKIP_EN to drop zero-valued nodes instead of issuing them.
module relu_layer2_sequencer #(
    parameter int RELU_NODES  = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int VALUE_WIDTH = 16,
    parameter int COUNT_WIDTH = 5,
    parameter int POP_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   flush,
    output logic                   q_write_en,
    output logic                   q_dequeue,
    input  logic [INDEX_WIDTH-1:0] q_index,
    input  logic [VALUE_WIDTH-1:0] q_value,
    output logic                   mac_valid,
    input  logic                   mac_ready,
    output logic [INDEX_WIDTH-1:0] mac_index,
    output logic [VALUE_WIDTH-1:0] mac_value,
    output logic                   mac_last,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] issued_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        POP,
        WAIT,
        ISSUE,
        DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LastNode =
        COUNT_WIDTH'(RELU_NODES - 1);
    localparam logic [2:0] PopLat = 3'(POP_LATENCY);

`ifdef RELU_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    state_t                 state;
    state_t                 stateNext;
    logic [COUNT_WIDTH-1:0] nodeCnt;
    logic [COUNT_WIDTH-1:0] nodeCntNext;
    logic [COUNT_WIDTH-1:0] issuedCnt;
    logic [COUNT_WIDTH-1:0] issuedNext;
    logic [2:0]             waitCnt;
    logic [2:0]             waitCntNext;
    logic [INDEX_WIDTH-1:0] holdIndex;
    logic [VALUE_WIDTH-1:0] holdValue;
    logic                   capture;
    logic                   isLast;

    assign isLast = (nodeCnt == LastNode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            nodeCnt   <= '0;
            issuedCnt <= '0;
            waitCnt   <= '0;
            holdIndex <= '0;
            holdValue <= '0;
        end else begin
            state     <= stateNext;
            nodeCnt   <= nodeCntNext;
            issuedCnt <= issuedNext;
            waitCnt   <= waitCntNext;
            if (capture) begin
                holdIndex <= q_index;
                holdValue <= q_value;
            end
        end
    end

    // Flush overrides everything, including a transfer on the same edge.
    always_comb begin
        stateNext   = state;
        nodeCntNext = nodeCnt;
        issuedNext  = issuedCnt;
        waitCntNext = waitCnt;
        capture     = 1'b0;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        stateNext  = LOAD;
                        issuedNext = '0;
                    end
                end
                LOAD: begin
                    nodeCntNext = '0;
                    stateNext   = POP;
                end
                POP: begin
                    waitCntNext = PopLat;
                    stateNext   = WAIT;
                end
                WAIT: begin
                    if (waitCnt <= 3'd1) begin
                        capture = 1'b1;
                        if (ZeroSkip && q_value == '0) begin
                            if (isLast) begin
                                stateNext = DONE;
                            end else begin
                                nodeCntNext = nodeCnt + COUNT_WIDTH'(1);
                                stateNext   = POP;
                            end
                        end else begin
                            stateNext = ISSUE;
                        end
                    end else begin
                        waitCntNext = waitCnt - 3'd1;
                    end
                end
                ISSUE: begin
                    if (mac_ready) begin
                        issuedNext = issuedCnt + COUNT_WIDTH'(1);
                        if (isLast) begin
                            stateNext = DONE;
                        end else begin
                            nodeCntNext = nodeCnt + COUNT_WIDTH'(1);
                            stateNext   = POP;
                        end
                    end
                end
                DONE: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign q_write_en   = (state == LOAD);
    assign q_dequeue    = (state == POP);
    assign mac_valid    = (state == ISSUE);
    assign mac_last     = (state == ISSUE) && isLast;
    assign mac_index    = holdIndex;
    assign mac_value    = holdValue;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign issued_count = issuedCnt;

endmodule

// File: tb/tb_relu_layer2_sequencer.sv
// Randomized bench for relu_layer2_sequencer with a queue model
// and a transfer-list scoreboard derived from the node data.
module tb_relu_layer2_sequencer;

    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int VW  = 16;
    localparam int CW  = 5;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          mac_ready = 1'b0;
    logic [IW-1:0] q_index = '0;
    logic [VW-1:0] q_value = '0;
    logic          q_write_en;
    logic          q_dequeue;
    logic          mac_valid;
    logic [IW-1:0] mac_index;
    logic [VW-1:0] mac_value;
    logic          mac_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] issued_count;

    always #5 clk = ~clk;

    relu_layer2_sequencer #(
        .RELU_NODES (N),
        .INDEX_WIDTH(IW),
        .VALUE_WIDTH(VW),
        .COUNT_WIDTH(CW),
        .POP_LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .flush       (flush),
        .q_write_en  (q_write_en),
        .q_dequeue   (q_dequeue),
        .q_index     (q_index),
        .q_value     (q_value),
        .mac_valid   (mac_valid),
        .mac_ready   (mac_ready),
        .mac_index   (mac_index),
        .mac_value   (mac_value),
        .mac_last    (mac_last),
        .busy        (busy),
        .done        (done),
        .issued_count(issued_count)
    );

    typedef struct {
        int idx;
        int val;
        bit last;
    } xfer_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [IW-1:0] nodeIdx[N];
    logic [VW-1:0] nodeVal[N];
    xfer_t         expQ[$];
    int ptr, pend, cyc, stalls, skips, xfers, writes, deqs, dones;
    int lastCycles, expCount, expFirst, rmode, stallLeft;
    int flushAfter, startMid;
    bit wasBusy, held, firstSeen, flushed, expLast;
    logic [IW-1:0] heldIdx;
    logic [VW-1:0] heldVal;

    // One cycle: drive inputs for the coming edge, then score the outputs.
    task automatic step();
        xfer_t e;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        case (rmode)
            1: begin
                mac_ready = !(mac_valid && mac_index == IW'(3)
                              && stallLeft > 0);
                if (!mac_ready) stallLeft--;
            end
            2: mac_ready = ($urandom_range(0, 3) != 0);
            default: mac_ready = 1'b1;
        endcase
        if (flushAfter > 0 && xfers == flushAfter && busy && !flushed) begin
            flush   = 1'b1;
            flushed = 1'b1;
        end
        if (startMid != 0 && mac_valid && xfers == 7) start = 1'b1;

        if (q_write_en || q_dequeue)
            check("wr_deq_exclusive", 32'(q_write_en && q_dequeue), 0);
        if (q_write_en) begin
            writes++;
            ptr = 0;
        end
        if (q_dequeue) begin
            deqs++;
            pend    = LAT;
            q_index = ~IW'(ptr);
            q_value = 16'hDEAD;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0 && ptr < N) begin
                q_index = nodeIdx[ptr];
                q_value = nodeVal[ptr];
                ptr++;
            end
        end

        if (busy && !wasBusy) begin
            cyc = 0;
            check("load_strobe", 32'(q_write_en), 1);
            check("count_cleared", 32'(issued_count), 0);
        end else begin
            cyc++;
        end
        wasBusy = busy;

        if (mac_valid && !firstSeen) begin
            firstSeen = 1'b1;
            check("first_valid_cycle", cyc, expFirst);
        end
        if (held) begin
            check("hold_valid", 32'(mac_valid), 1);
            check("hold_index", 32'(mac_index), 32'(heldIdx));
            check("hold_value", 32'(mac_value), 32'(heldVal));
        end
        held = mac_valid && !mac_ready && !flush;
        if (held) begin
            stalls++;
            heldIdx = mac_index;
            heldVal = mac_value;
        end
        if (mac_last) lastCycles++;

        if (mac_valid && mac_ready && !flush) begin
            xfers++;
            if (expQ.size() == 0) begin
                check("extra_transfer", xfers, expCount);
            end else begin
                e = expQ.pop_front();
                check("xfer_index", 32'(mac_index), e.idx);
                check("xfer_value", 32'(mac_value), e.val);
                check("xfer_last", 32'(mac_last), 32'(e.last));
            end
        end

        if (done) begin
            dones++;
            check("done_cycle", cyc, 1 + (2 + LAT) * N - skips + stalls);
            check("done_issued", 32'(issued_count), expCount);
            check("done_pending", expQ.size(), 0);
            check("done_dequeues", deqs, N);
            check("done_writes", writes, 1);
            check("done_last_seen", 32'(lastCycles > 0), 32'(expLast));
        end
    endtask

    task automatic runPass(input int pat, input int rm,
                           input int fa, input int sm, input int rsm);
        bit fin;
        bit skipIt;
        int lead;
        xfer_t e;
        expQ.delete();
        skips    = 0;
        expCount = 0;
        expLast  = 1'b0;
        lead     = -1;
        for (int i = 0; i < N; i++) begin
            nodeIdx[i] = IW'(i);
            case (pat)
                0: nodeVal[i] = VW'(i + 1);
                1: nodeVal[i] = (i % 2 == 1) ? 16'h0100 : 16'h0000;
                default: begin
                    nodeIdx[i] = IW'($urandom);
                    nodeVal[i] = ($urandom_range(0, 3) == 0) ?
                                 16'h0000 : VW'($urandom);
                end
            endcase
            if (pat == 3 && i == N - 1) nodeVal[i] = 16'h0000;
`ifdef RELU_ZERO_SKIP_EN
            skipIt = (nodeVal[i] == 0);
`else
            skipIt = 1'b0;
`endif
            if (skipIt) begin
                skips++;
            end else begin
                if (lead < 0) lead = skips;
                e.idx  = int'(nodeIdx[i]);
                e.val  = int'(nodeVal[i]);
                e.last = (i == N - 1);
                expQ.push_back(e);
                expCount++;
                if (i == N - 1) expLast = 1'b1;
            end
        end
        expFirst   = (lead < 0) ? -1 : (lead + 1) * (1 + LAT) + 1;
        ptr        = 0;
        pend       = 0;
        cyc        = 0;
        stalls     = 0;
        xfers      = 0;
        writes     = 0;
        deqs       = 0;
        dones      = 0;
        lastCycles = 0;
        held       = 1'b0;
        firstSeen  = 1'b0;
        flushed    = 1'b0;
        rmode      = rm;
        stallLeft  = 5;
        flushAfter = fa;
        startMid   = sm;
        fin        = 1'b0;
        start      = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            step();
            if (rsm > 0 && mac_valid && xfers == rsm) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_valid", 32'(mac_valid), 0);
                check("rst_last", 32'(mac_last), 0);
                check("rst_index", 32'(mac_index), 0);
                check("rst_value", 32'(mac_value), 0);
                check("rst_count", 32'(issued_count), 0);
                check("rst_strobes", 32'({q_write_en, q_dequeue, done}), 0);
                @(negedge clk);
                reset_n = 1'b1;
                wasBusy = 1'b0;
                held    = 1'b0;
                fin     = 1'b1;
            end else if (done) begin
                step();
                check("done_pulse_width", 32'(done), 0);
                check("idle_after_done", 32'(busy), 0);
                fin = 1'b1;
            end else if (flushed) begin
                step();
                check("flush_busy", 32'(busy), 0);
                check("flush_valid", 32'(mac_valid), 0);
                check("flush_dequeue", 32'(q_dequeue), 0);
                check("flush_count", 32'(issued_count), fa);
                repeat (6) step();
                check("flush_no_done", dones, 0);
                check("flush_count_held", 32'(issued_count), fa);
                fin = 1'b1;
            end
        end
        if (!fin) check("pass_timeout", 0, 1);
    endtask

    initial begin
        rmode      = 0;
        flushAfter = 0;
        startMid   = 0;
        wasBusy    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(mac_valid), 0);
        check("reset_count", 32'(issued_count), 0);
        check("reset_strobes", 32'({q_write_en, q_dequeue, done}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_beats_start", 32'(busy), 0);
        start = 1'b0;
        @(negedge clk);
        check("flush_idle_noop", 32'(busy), 0);
        flush = 1'b0;

        runPass(0, 0, 0, 0, 3);
        runPass(0, 0, 0, 0, 0);
        runPass(0, 1, 0, 0, 0);
        runPass(1, 0, 0, 0, 0);
        runPass(3, 0, 0, 0, 0);
        runPass(0, 0, 5, 0, 0);
        runPass(0, 0, 0, 0, 0);
        runPass(0, 0, 0, 1, 0);
        for (int r = 0; r < 4; r++) runPass(2, 2, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
